w_seq_gen: RTL and testbench

W_SEQ_GEN -- requirements
Module: w_seq_gen

---
 rtl/w_seq_gen_pkg.sv | 24 ++
 rtl/w_shift_reg.sv | 40 ++++
 rtl/w_seq_gen.sv | 130 +++++++++++++
 tb/tb_w_seq_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/w_seq_gen_pkg.sv
// Shared definitions for the serial w-stream generator and its companion detector bench:
// state encodings, default pattern width and the len field width.
package w_seq_gen_pkg;

  localparam int W_DEFAULT_WIDTH = 16;
  localparam int LEN_W           = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Requests longer than the register are trimmed to the register width.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l,
                                                 input int unsigned     max_len);
    if (32'(l) > max_len) begin
      clamp_len = LEN_W'(max_len);
    end else begin
      clamp_len = l;
    end
  endfunction

endpackage

// File: rtl/w_shift_reg.sv
// Loadable LSB-first shift register; keeps a copy of the loaded pattern so
// repeated passes can restart from bit 0 without a bubble.
module w_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic             reload,
  input  logic             clear,
  input  logic [WIDTH-1:0] pattern,
  output logic             bit_out
);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] saved_r;

  // Shift/hold/reload datapath; clear wins so w is 0 whenever the FSM leaves SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= '0;
      saved_r <= '0;
    end else if (clear) begin
      shift_r <= '0;
    end else if (load) begin
      shift_r <= pattern;
      saved_r <= pattern;
    end else if (reload) begin
      shift_r <= saved_r;
    end else if (advance) begin
      shift_r <= {1'b0, shift_r[WIDTH-1:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  assign bit_out = shift_r[0];

endmodule

// File: rtl/w_seq_gen.sv
// Serial w-stream generator: accepts a pattern request and emits len bits LSB first,
// (repeat_cnt+1) times, advancing one bit per tick, then pulses done.
module w_seq_gen
  import w_seq_gen_pkg::*;
#(
  parameter int WIDTH = W_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       repeat_cnt,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_r, state_n;
  logic [LEN_W-1:0] idx_r, idx_n;
  logic [LEN_W-1:0] len_r, len_n;
  logic [3:0]       rep_r, rep_n;
  logic             w_valid_r, busy_r, done_r, ready_r;
  logic [LEN_W-1:0] len_cl_s;
  logic             sr_load_s, sr_adv_s, sr_reload_s, sr_clear_s;

  assign len_cl_s = clamp_len(len, WIDTH);

  // Next-state, counter and shift-register control decode.
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    len_n       = len_r;
    rep_n       = rep_r;
    sr_load_s   = 1'b0;
    sr_adv_s    = 1'b0;
    sr_reload_s = 1'b0;
    sr_clear_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_valid) begin
          len_n = len_cl_s;
          rep_n = repeat_cnt;
          idx_n = '0;
          if (len_cl_s == 5'd0) begin
            state_n = ST_DONE;
          end else begin
            state_n   = ST_SHIFT;
            sr_load_s = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (idx_r == len_r - 5'd1) begin
            idx_n = '0;
            if (rep_r != 4'd0) begin
              rep_n       = rep_r - 4'd1;
              sr_reload_s = 1'b1;
            end else begin
              state_n    = ST_DONE;
              sr_clear_s = 1'b1;
            end
          end else begin
            idx_n    = idx_r + 5'd1;
            sr_adv_s = 1'b1;
          end
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        rep_n   = 4'd0;
      end
      default: begin
        state_n    = ST_IDLE;
        idx_n      = '0;
        rep_n      = 4'd0;
        sr_clear_s = 1'b1;
      end
    endcase
  end

  // State, counters and output flags, all registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      len_r     <= '0;
      rep_r     <= 4'd0;
      w_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      len_r     <= len_n;
      rep_r     <= rep_n;
      w_valid_r <= (state_n == ST_SHIFT);
      busy_r    <= (state_n != ST_IDLE);
      done_r    <= (state_n == ST_DONE);
      ready_r   <= (state_n == ST_IDLE);
    end
  end

  w_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (sr_load_s),
    .advance (sr_adv_s),
    .reload  (sr_reload_s),
    .clear   (sr_clear_s),
    .pattern (pattern),
    .bit_out (w)
  );

  assign w_valid    = w_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign load_ready = ready_r;

endmodule

// File: tb/tb_w_seq_gen.sv
// Directed bench for w_seq_gen: a request table with hand-computed bit streams,
// plus tick-gapped, mid-transfer reset and detector-loopback sequences.
module tb_w_seq_gen;
  import w_seq_gen_pkg::*;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [3:0]       repeat_cnt;
  logic             w, w_valid, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  w_seq_gen #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern    (pattern),
    .len        (len),
    .repeat_cnt (repeat_cnt),
    .w          (w),
    .w_valid    (w_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic [3:0]  rep;
    logic [31:0] bits;   // expected stream, bit i = i-th emitted bit
    int          nbits;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    check("ready_before", 32'(load_ready), 32'd1);
    tick       = 1'b1;
    load_valid = 1'b1;
    pattern    = v.pat;
    len        = v.len;
    repeat_cnt = v.rep;
    step();
    // Scramble inputs and keep requesting: captured values must win, request ignored while busy.
    pattern    = ~v.pat;
    len        = 5'd7;
    repeat_cnt = 4'd9;
    for (int i = 0; i < v.nbits; i++) begin
      check("w_valid", 32'(w_valid), 32'd1);
      check("w_bit", 32'(w), 32'(v.bits[i]));
      check("busy", 32'(busy), 32'd1);
      step();
    end
    load_valid = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_w_valid", 32'(w_valid), 32'd0);
    check("done_ready", 32'(load_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_w", 32'(w), 32'd0);
    step();
    check("idle_done", 32'(done), 32'd0);
    check("idle_ready", 32'(load_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_w_valid", 32'(w_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   zeros_run, ones_run, z4_at, o4_at, nvalid;
    vec_t vg;

    vecs[0] = '{16'h000F, 5'd8,  4'd0, 32'h0000_000F, 8};
    vecs[1] = '{16'h0005, 5'd3,  4'd2, 32'h0000_016D, 9};
    vecs[2] = '{16'hA5C3, 5'd20, 4'd0, 32'h0000_A5C3, 16};  // clamped to 16
    vecs[3] = '{16'h8001, 5'd16, 4'd1, 32'h8001_8001, 32};
    vecs[4] = '{16'h0002, 5'd2,  4'd3, 32'h0000_00AA, 8};
    vecs[5] = '{16'h0001, 5'd1,  4'd0, 32'h0000_0001, 1};
    vecs[6] = '{16'hFFFF, 5'd0,  4'd5, 32'h0000_0000, 0};   // nothing sent

    reset      = 1'b0;
    tick       = 1'b0;
    load_valid = 1'b0;
    pattern    = '0;
    len        = '0;
    repeat_cnt = '0;
    #12;
    check("rst_w", 32'(w), 32'd0);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    step();
    reset = 1'b1;
    step();

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    // tick every third cycle: each bit of 1,0,0,1 held three cycles
    tick       = 1'b0;
    load_valid = 1'b1;
    pattern    = 16'h0009;
    len        = 5'd4;
    repeat_cnt = 4'd0;
    step();
    load_valid = 1'b0;
    vg.bits = 32'h0000_0009;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 3; c++) begin
        check("gap_w_valid", 32'(w_valid), 32'd1);
        check("gap_w", 32'(w), 32'(vg.bits[b]));
        check("gap_done", 32'(done), 32'd0);
        tick = (c == 2);
        step();
      end
    end
    tick = 1'b0;
    check("gap_done_pulse", 32'(done), 32'd1);
    step();
    check("gap_idle_ready", 32'(load_ready), 32'd1);

    // reset pulse while bit 5 of a 12-bit all-ones request is on w
    tick       = 1'b1;
    load_valid = 1'b1;
    pattern    = 16'h0FFF;
    len        = 5'd12;
    repeat_cnt = 4'd0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_w", 32'(w), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_w", 32'(w), 32'd0);
    check("abort_w_valid", 32'(w_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(load_ready), 32'd1);
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_valid", 32'(w_valid), 32'd0);
      step();
    end
    run_vec(vecs[0]);

    // detector loopback: 0000 1111 0000 -> four zeros after bit 3, four ones after bit 7
    zeros_run = 0; ones_run = 0; z4_at = -1; o4_at = -1; nvalid = 0;
    tick       = 1'b1;
    load_valid = 1'b1;
    pattern    = 16'h00F0;
    len        = 5'd12;
    repeat_cnt = 4'd0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (w_valid) begin
        nvalid++;
        if (w) begin
          ones_run++;
          zeros_run = 0;
        end else begin
          zeros_run++;
          ones_run = 0;
        end
        if (zeros_run == 4 && z4_at < 0) z4_at = i;
        if (ones_run == 4 && o4_at < 0) o4_at = i;
      end
      step();
    end
    check("det_four_zeros_cycle", 32'(z4_at), 32'd3);
    check("det_four_ones_cycle", 32'(o4_at), 32'd7);
    check("det_bit_count", 32'(nvalid), 32'd12);
    check("det_final_ready", 32'(load_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
